// File: rtl/sm_regdump.sv
// sm_regdump
// Debug-port reader for the CPU regAddr/regData debug interface. A start pulse
// sweeps regAddr over FIRST_REG..LAST_REG. For each index it snapshots regData
// once and emits the line "NN:HHHHHHHH\r\n" as uppercase ASCII on a valid/ready
// byte stream. The stream is intended to feed a UART transmitter.
//
// Ports
//   clk       in   1   single clock
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   one-cycle dump request, ignored while busy or during done
//   busy      out  1   high from the cycle after an accepted start until the final byte is taken
//   done      out  1   one-cycle pulse in the cycle after the final byte is taken
//   regAddr   out  5   debug index presented to the CPU
//   regData   in   32  debug data returned by the CPU
//   tx_data   out  8   ASCII byte
//   tx_valid  out  1   tx_data holds a byte
//   tx_ready  in   1   sink takes tx_data when tx_valid && tx_ready
//
// Per index the sequence is SETUP (1) + WAIT (READ_LAT) + LATCH (1) + EMIT (13
// bytes). The end-of-line decision (advance the index or finish) is made in the
// same cycle as the final byte transfer, so no cycle is spent between indices.
// All outputs come straight from flops.

module sm_regdump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Reject parameter combinations that cannot be swept or counted.
  if (FIRST_REG > LAST_REG) begin : g_bad_range
    $error("sm_regdump: FIRST_REG must not exceed LAST_REG");
  end
  if ((FIRST_REG < 0) || (LAST_REG > 31)) begin : g_bad_index
    $error("sm_regdump: debug indices must lie in 0..31");
  end
  if ((READ_LAT < 0) || (READ_LAT > 7)) begin : g_bad_lat
    $error("sm_regdump: READ_LAT must lie in 0..7");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  localparam logic [2:0] LAT       = 3'(READ_LAT);
  localparam logic [3:0] LAST_BYTE = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  state_t      state_r,    state_s;
  logic [4:0]  idx_r,      idx_s;
  logic [2:0]  wait_cnt_r, wait_cnt_s;
  logic [3:0]  byte_cnt_r, byte_cnt_s;
  logic [31:0] shadow_r,   shadow_s;
  logic        busy_r,     busy_s;
  logic        done_r,     done_s;
  logic [7:0]  tx_data_r,  tx_data_s;
  logic        tx_valid_r, tx_valid_s;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] h;
    if (n < 4'd10) begin
      h = 8'h30 + {4'h0, n};
    end else begin
      h = 8'h37 + {4'h0, n};
    end
    return h;
  endfunction

  // Byte k (0..12) of the line "NN:HHHHHHHH\r\n" for the given index and value.
  function automatic logic [7:0] line_byte(input logic [3:0]  k,
                                           input logic [4:0]  idx,
                                           input logic [31:0] val);
    logic [7:0] b;
    b = 8'h00;
    case (k)
      4'd0:    b = hex_ascii({3'b000, idx[4]});
      4'd1:    b = hex_ascii(idx[3:0]);
      4'd2:    b = 8'h3A;
      4'd3:    b = hex_ascii(val[31:28]);
      4'd4:    b = hex_ascii(val[27:24]);
      4'd5:    b = hex_ascii(val[23:20]);
      4'd6:    b = hex_ascii(val[19:16]);
      4'd7:    b = hex_ascii(val[15:12]);
      4'd8:    b = hex_ascii(val[11:8]);
      4'd9:    b = hex_ascii(val[7:4]);
      4'd10:   b = hex_ascii(val[3:0]);
      4'd11:   b = 8'h0D;
      4'd12:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state and next-output decode for the dump sequencer.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    wait_cnt_s = wait_cnt_r;
    byte_cnt_s = byte_cnt_r;
    shadow_s   = shadow_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        // A start landing on the done pulse belongs to the finished dump and is dropped.
        if (start && !done_r) begin
          state_s = S_SETUP;
          idx_s   = FIRST_IDX;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_SETUP: begin
        wait_cnt_s = LAT;
        if (LAT == 3'd0) begin
          state_s = S_LATCH;
        end else begin
          state_s = S_WAIT;
        end
      end

      S_WAIT: begin
        wait_cnt_s = wait_cnt_r - 3'd1;
        if (wait_cnt_r <= 3'd1) begin
          state_s = S_LATCH;
        end else begin
          state_s = S_WAIT;
        end
      end

      S_LATCH: begin
        shadow_s   = regData;
        byte_cnt_s = 4'd0;
        state_s    = S_EMIT;
      end

      S_EMIT: begin
        if (tx_valid_r && tx_ready) begin
          if (byte_cnt_r == LAST_BYTE) begin
            // Compare before incrementing so LAST_REG=31 never wraps to 0.
            if (idx_r == LAST_IDX) begin
              state_s = S_IDLE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              idx_s   = idx_r + 5'd1;
              state_s = S_SETUP;
            end
          end else begin
            byte_cnt_s = byte_cnt_r + 4'd1;
          end
        end else begin
          // Sink stalled: hold the current byte.
          state_s = S_EMIT;
        end
      end

      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase

    // The byte is prepared one cycle ahead so tx_data/tx_valid are flops and
    // never depend on tx_ready within the same cycle.
    tx_valid_s = (state_s == S_EMIT);
    tx_data_s  = tx_valid_s ? line_byte(byte_cnt_s, idx_s, shadow_s) : 8'h00;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      idx_r      <= FIRST_IDX;
      wait_cnt_r <= 3'd0;
      byte_cnt_r <= 4'd0;
      shadow_r   <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      wait_cnt_r <= wait_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shadow_r   <= shadow_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign regAddr  = idx_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;

endmodule
